// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// MMIO address constants are used only when DMEM_MMIO_EN is defined.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam int DMEM_DEPTH_WORDS_DEFAULT = 32;
  localparam int DMEM_LATENCY_DEFAULT     = 1;
  localparam int CNT_W                    = 4;

  localparam logic [31:0] MMIO_TOHOST_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] MMIO_CYCLE_ADDR  = 32'hFFFF_FFF4;

endpackage

// File: rtl/dmem_ram_array.sv
// Word-wide synchronous RAM with per-byte write enables and a registered read port.
// The read register only updates on re, so it holds the last load result.
module dmem_ram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS_DEFAULT,
  parameter int AW          = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: IDLE -> WAIT (LATENCY cycles) -> RESP with a one-cycle ready.
// Optional MMIO (TOHOST register, cycle counter) is built when DMEM_MMIO_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS_DEFAULT,
  parameter int LATENCY     = DMEM_LATENCY_DEFAULT   // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output dmem_state_e dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture, commit;

  logic             we_q;
  logic [29:0]      idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;

  logic             err_q;
  logic             src_ram_q;
  logic [31:0]      rdata_q;
  logic [31:0]      ram_rdata;

  logic             in_range, mmio_hit, ram_sel;
  logic [31:0]      mmio_rdata;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit  = rst;  // a reset edge abandons the transaction without side effects
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      we_q    <= we;
      idx_q   <= addr[31:2];
      wdata_q <= wdata;
      be_q    <= be;
    end
  end

  assign in_range = ({2'b00, idx_q} < 32'(DEPTH_WORDS));
  assign ram_sel  = in_range && !mmio_hit;

`ifdef DMEM_MMIO_EN
  logic [31:0] tohost_q, cycle_q;
  logic        hit_tohost, hit_cycle;

  assign hit_tohost = (idx_q == MMIO_TOHOST_ADDR[31:2]);
  assign hit_cycle  = (idx_q == MMIO_CYCLE_ADDR[31:2]);
  assign mmio_hit   = hit_tohost || hit_cycle;
  assign mmio_rdata = hit_tohost ? tohost_q : cycle_q;

  // Stores to the cycle counter are accepted but have no effect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tohost_q <= '0;
      cycle_q  <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (commit && we_q && hit_tohost) begin
        for (int i = 0; i < 4; i++) begin
          if (be_q[i]) tohost_q[8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end
`else
  assign mmio_hit   = 1'b0;
  assign mmio_rdata = '0;
`endif

  dmem_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .we   (commit && we_q && ram_sel),
    .re   (commit && !we_q && ram_sel),
    .be   (be_q),
    .addr (idx_q[AW-1:0]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // rdata comes from the RAM read register for RAM loads, else from rdata_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q     <= 1'b0;
      src_ram_q <= 1'b0;
      rdata_q   <= '0;
    end else if (commit) begin
      err_q <= !(in_range || mmio_hit);
      if (!(in_range || mmio_hit)) begin
        src_ram_q <= 1'b0;
        rdata_q   <= '0;
      end else if (!we_q) begin
        src_ram_q <= ram_sel;
        if (!ram_sel) rdata_q <= mmio_rdata;
      end
    end
  end

  assign ready     = (state_q == RESP);
  assign err       = (state_q == RESP) && err_q;
  assign rdata     = src_ram_q ? ram_rdata : rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one LATENCY=1 and one LATENCY=3 instance.
// Define DMEM_MMIO_EN to exercise the TOHOST register and cycle counter.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  dmem_state_e st    [2];

  int          lat_exp [2] = '{1, 3};
  int          cmp_cnt = 0;
  int          mis_cnt = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [31:0] exp_q [$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  dmem_responder #(.DEPTH_WORDS(32), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
    .be(be[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0]), .dbg_state(st[0])
  );

  dmem_responder #(.DEPTH_WORDS(32), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
    .be(be[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1]), .dbg_state(st[1])
  );

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One transaction on instance d; inputs are scrambled after acceptance to show they are ignored.
  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] b, output logic [31:0] rd, output logic e);
    bit seen;
    int k;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    req[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom;
    be[d] = 4'($urandom);
    rd = '0; e = 1'b0; seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (ready[d]) begin
        seen = 1'b1;
        rd = rdata[d];
        e = err[d];
      end
    end
    check($sformatf("latency_d%0d", d), seen ? k : -1, lat_exp[d]);
    @(posedge clk);
    @(negedge clk);
    check($sformatf("ready_pulse_d%0d", d), {30'd0, ready[d], err[d]}, 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [31:0] rd, v1, v2;
    logic        e;
    int          a1, a2, n_ready, last_k;

    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; be[d] = '0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_outputs_d%0d", d), {30'd0, ready[d], err[d]}, 32'd0);
      check($sformatf("reset_rdata_d%0d", d), rdata[d], 32'd0);
      check($sformatf("reset_state_d%0d", d), 32'(st[d]), 32'(IDLE));
    end
    rst = 1'b1;

    // basic store / load, LATENCY=1
    access(0, 1'b1, 32'h0, 32'h0000_000A, 4'hF, rd, e);
    check("store0_err", 32'(e), 32'd0);
    access(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, e);
    check("load0_rdata", rd, 32'h0000_000A);

    // byte-lane merge
    access(0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, rd, e);
    access(0, 1'b1, 32'h8, 32'h00AB_0000, 4'b0100, rd, e);
    access(0, 1'b0, 32'h8, 32'h0, 4'hF, rd, e);
    check("lane_merge", rd, 32'hFFAB_FFFF);

    // be=0000 store completes without error or change; load ignores be; addr[1:0] ignored
    access(0, 1'b1, 32'h8, 32'h1234_5678, 4'b0000, rd, e);
    check("be0_err", 32'(e), 32'd0);
    access(0, 1'b0, 32'hB, 32'h0, 4'b0000, rd, e);
    check("be0_nochange", rd, 32'hFFAB_FFFF);

    // LATENCY=3: boundary word and out-of-range accesses
    access(1, 1'b1, 32'h0, 32'h1111_1111, 4'hF, rd, e);
    access(1, 1'b1, 32'h7C, 32'hCAFE_0123, 4'hF, rd, e);
    access(1, 1'b0, 32'h7C, 32'h0, 4'hF, rd, e);
    check("last_word", rd, 32'hCAFE_0123);
    check("last_word_err", 32'(e), 32'd0);
    access(1, 1'b0, 32'h80, 32'h0, 4'hF, rd, e);
    check("oor_load_err", 32'(e), 32'd1);
    check("oor_load_rdata", rd, 32'd0);
    access(1, 1'b1, 32'h80, 32'hDEAD_BEEF, 4'hF, rd, e);
    check("oor_store_err", 32'(e), 32'd1);
    access(1, 1'b0, 32'h0, 32'h0, 4'hF, rd, e);
    check("oor_ram_unchanged", rd, 32'h1111_1111);

    // req held high: back-to-back loads, accepted the cycle after each ready
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_000A);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0; be[0] = 4'h0;
    n_ready = 0; last_k = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready[0]) begin
        n_ready++;
        if (last_k >= 0) check("burst_gap", k - last_k, 32'd3);
        last_k = k;
        if (exp_q.size() > 0) check("burst_rdata", rdata[0], exp_q.pop_front());
      end
    end
    req[0] = 1'b0;
    check("burst_count", n_ready, 32'd4);

    // reset during WAIT abandons the store on both instances
    access(0, 1'b1, 32'h4, 32'h0BAD_F00D, 4'hF, rd, e);
    access(1, 1'b1, 32'h4, 32'h0BAD_F00D, 4'hF, rd, e);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b1; we[d] = 1'b1; addr[d] = 32'h4; wdata[d] = 32'h0000_0055; be[d] = 4'hF;
    end
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0; req[1] = 1'b0;
    check("pre_reset_state_d1", 32'(st[1]), 32'(WAIT));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("post_reset_rdata_d0", rdata[0], 32'd0);
    n_ready = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (ready[0] || ready[1]) n_ready++;
    end
    check("reset_no_ready", n_ready, 32'd0);
    access(0, 1'b0, 32'h4, 32'h0, 4'hF, rd, e);
    check("reset_abandon_d0", rd, 32'h0BAD_F00D);
    access(1, 1'b0, 32'h4, 32'h0, 4'hF, rd, e);
    check("reset_abandon_d1", rd, 32'h0BAD_F00D);
    access(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, e);
    check("ram_kept_over_reset", rd, 32'h0000_000A);

`ifdef DMEM_MMIO_EN
    access(0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0001, 4'hF, rd, e);
    check("tohost_store_err", 32'(e), 32'd0);
    access(0, 1'b0, 32'hFFFF_FFF0, 32'h0, 4'hF, rd, e);
    check("tohost_value", rd, 32'h0000_0001);
    access(0, 1'b1, 32'hFFFF_FFF0, 32'h0000_AB00, 4'b0010, rd, e);
    access(0, 1'b0, 32'hFFFF_FFF0, 32'h0, 4'hF, rd, e);
    check("tohost_lane", rd, 32'h0000_AB01);
    access(0, 1'b1, 32'hFFFF_FFF4, 32'h0, 4'hF, rd, e);
    check("cycle_store_err", 32'(e), 32'd0);
    access(0, 1'b0, 32'hFFFF_FFF4, 32'h0, 4'hF, rd, e);
    v1 = rd; a1 = acc_cyc;
    repeat (5) @(negedge clk);
    access(0, 1'b0, 32'hFFFF_FFF4, 32'h0, 4'hF, rd, e);
    v2 = rd; a2 = acc_cyc;
    check("cycle_delta", v2 - v1, 32'(a2 - a1));
`else
    access(0, 1'b0, 32'hFFFF_FFF0, 32'h0, 4'hF, rd, e);
    check("no_mmio_tohost_err", 32'(e), 32'd1);
    check("no_mmio_tohost_rdata", rd, 32'd0);
    access(0, 1'b0, 32'hFFFF_FFF4, 32'h0, 4'hF, rd, e);
    check("no_mmio_cycle_err", 32'(e), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
